fire_ofm_writer: RTL and testbench

Output-side collector for the fire expand layers. It captures the `DSP_NO` parallel ReLU-clamped results a layer presents on each sample pulse and serializes them into the feature-map RAM write port, one word per cycle. It tracks the pixel count and raises the RAM feedback that tells the layer its whole output map is stored. It sits between an expand MAC array (its `ofm` bus and sample strobe) and the next layer's input RAM.

---
 rtl/fire_ofm_writer.sv | 139 +++++++++++++
 tb/tb_fire_ofm_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fire_ofm_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fire_ofm_writer: serializes DSP_NO parallel expand results into the      |
// | feature-map RAM write port, channel-major, and flags a fully stored map. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fire_ofm_writer #(
  parameter int DSP_NO    = 128,
  parameter int WIDTH     = 16,
  parameter int WOUT      = 32,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              layer_en,
  input  logic              sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_wdata,
  output logic              busy,
  output logic              ram_feedback,
  output logic              layer_stored,
  output logic              overrun
);

  localparam int NPIX  = WOUT * WOUT;
  localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX - 1);

  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             stored_q, stored_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] shadow_q [0:DSP_NO-1];

  logic             w_last_ch;
  logic             w_final;
  logic             w_accept;
  logic             w_drop;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      pix_q     <= '0;
      stored_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      pix_q     <= pix_d;
      stored_q  <= stored_d;
      overrun_q <= overrun_d;
    end
  end

  // Captured results are only read while writing, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      shadow_q <= ofm;
    end
  end

  // Next-state logic
  always_comb begin
    w_last_ch = (state_q == S_WRITE) && (ch_q == CH_LAST);
    w_final   = w_last_ch && (pix_q == PIX_LAST);
    // The final word of the final pixel cannot hand over to a new sample.
    w_accept  = layer_en && sample && !stored_q &&
                ((state_q == S_IDLE) || (w_last_ch && !w_final));
    w_drop    = layer_en && sample && !w_accept;

    state_d   = state_q;
    ch_d      = ch_q;
    pix_d     = pix_q;
    stored_d  = stored_q;
    overrun_d = overrun_q;

    if (!layer_en) begin
      state_d   = S_IDLE;
      ch_d      = '0;
      pix_d     = '0;
      stored_d  = 1'b0;
      overrun_d = 1'b0;
    end else begin
      if (w_drop) begin
        overrun_d = 1'b1;
      end
      if (state_q == S_WRITE) begin
        if (ch_q == CH_LAST) begin
          ch_d = '0;
          if (pix_q == PIX_LAST) begin
            pix_d    = '0;
            stored_d = 1'b1;
            state_d  = S_IDLE;
          end else begin
            pix_d   = pix_q + 1'b1;
            state_d = w_accept ? S_WRITE : S_IDLE;
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end else if (w_accept) begin
        state_d = S_WRITE;
        ch_d    = '0;
      end
    end
  end

  // Output logic: registered state only
  always_comb begin
    ram_we       = 1'b0;
    busy         = 1'b0;
    ram_feedback = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    layer_stored = stored_q;
    overrun      = overrun_q;
    if (state_q == S_WRITE) begin
      ram_we       = 1'b1;
      busy         = 1'b1;
      ram_feedback = w_final;
      ram_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(ch_q) * ADDR_W'(NPIX) + ADDR_W'(pix_q);
      ram_wdata    = shadow_q[ch_q];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fire_ofm_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fire_ofm_writer: directed vector table plus multi-cycle sequences.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fire_ofm_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        layer_en = 1'b0;
  logic        sample = 1'b0;
  logic [15:0] ofm [0:3];
  logic        ram_we;
  logic [5:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        busy;
  logic        ram_feedback;
  logic        layer_stored;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  fire_ofm_writer #(
    .DSP_NO(4), .WIDTH(16), .WOUT(2), .ADDR_W(6), .BASE_ADDR(8)
  ) dut (
    .clk(clk), .rst(rst), .layer_en(layer_en), .sample(sample), .ofm(ofm),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .busy(busy),
    .ram_feedback(ram_feedback), .layer_stored(layer_stored), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        r, e, s;
    logic [63:0] d;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wd;
    logic        bz, fb, st, ov;
  } vec_t;

  function automatic vec_t mk(input logic r, e, s, input logic [15:0] a, b, c, d,
                              input logic we, input logic [5:0] ad, input logic [15:0] wd,
                              input logic fb, st, ov);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.d = {a, b, c, d};
    v.we = we; v.addr = ad; v.wd = wd; v.bz = we; v.fb = fb; v.st = st; v.ov = ov;
    return v;
  endfunction

  task automatic drive(input logic r, e, s, input logic [63:0] d);
    rst = r; layer_en = e; sample = s;
    for (int k = 0; k < 4; k++) ofm[k] = d[63-16*k -: 16];
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [26:0] req);
    logic [26:0] act;
    act = {ram_we, ram_addr, ram_wdata, busy, ram_feedback, layer_stored, overrun};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual {we,addr,wdata,busy,fb,stored,ovr}=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_val(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  vec_t vecs [0:30];
  int   hits [0:63];
  int   writes, fbcount, idx, bad;

  initial begin
    for (int k = 0; k < 4; k++) ofm[k] = '0;

    // Row inputs apply for one cycle; expectations are the outputs after that edge.
    vecs[0]  = mk(1,0,0, 0,0,0,0,     0, 0, 0,  0,0,0);
    vecs[1]  = mk(0,1,1, 1,2,3,4,     1, 8, 1,  0,0,0);
    vecs[2]  = mk(0,1,0, 0,0,0,0,     1,12, 2,  0,0,0);
    vecs[3]  = mk(0,1,0, 0,0,0,0,     1,16, 3,  0,0,0);
    vecs[4]  = mk(0,1,0, 0,0,0,0,     1,20, 4,  0,0,0);
    vecs[5]  = mk(0,1,0, 0,0,0,0,     0, 0, 0,  0,0,0);
    vecs[6]  = mk(0,1,1, 5,6,7,8,     1, 9, 5,  0,0,0);
    vecs[7]  = mk(0,1,0, 0,0,0,0,     1,13, 6,  0,0,0);
    vecs[8]  = mk(0,1,0, 0,0,0,0,     1,17, 7,  0,0,0);
    vecs[9]  = mk(0,1,0, 0,0,0,0,     1,21, 8,  0,0,0);
    vecs[10] = mk(0,1,1, 9,10,11,12,  1,10, 9,  0,0,0);
    vecs[11] = mk(0,1,0, 0,0,0,0,     1,14,10,  0,0,0);
    vecs[12] = mk(0,1,0, 0,0,0,0,     1,18,11,  0,0,0);
    vecs[13] = mk(0,1,0, 0,0,0,0,     1,22,12,  0,0,0);
    vecs[14] = mk(0,1,0, 0,0,0,0,     0, 0, 0,  0,0,0);
    vecs[15] = mk(0,1,1, 13,14,15,16, 1,11,13,  0,0,0);
    vecs[16] = mk(0,1,1, 99,99,99,99, 1,15,14,  0,0,1);
    vecs[17] = mk(0,1,0, 0,0,0,0,     1,19,15,  0,0,1);
    vecs[18] = mk(0,1,0, 0,0,0,0,     1,23,16,  1,0,1);
    vecs[19] = mk(0,1,0, 0,0,0,0,     0, 0, 0,  0,1,1);
    vecs[20] = mk(0,1,1, 1,1,1,1,     0, 0, 0,  0,1,1);
    vecs[21] = mk(0,0,0, 0,0,0,0,     0, 0, 0,  0,0,0);
    vecs[22] = mk(0,0,1, 7,7,7,7,     0, 0, 0,  0,0,0);
    vecs[23] = mk(0,1,1, 21,22,23,24, 1, 8,21,  0,0,0);
    vecs[24] = mk(0,1,0, 0,0,0,0,     1,12,22,  0,0,0);
    vecs[25] = mk(0,0,0, 0,0,0,0,     0, 0, 0,  0,0,0);
    vecs[26] = mk(0,1,1, 31,32,33,34, 1, 8,31,  0,0,0);
    vecs[27] = mk(0,1,0, 0,0,0,0,     1,12,32,  0,0,0);
    vecs[28] = mk(0,1,0, 0,0,0,0,     1,16,33,  0,0,0);
    vecs[29] = mk(0,1,0, 0,0,0,0,     1,20,34,  0,0,0);
    vecs[30] = mk(0,1,0, 0,0,0,0,     0, 0, 0,  0,0,0);

    for (int i = 0; i < 31; i++) begin
      drive(vecs[i].r, vecs[i].e, vecs[i].s, vecs[i].d);
      check_outs($sformatf("vec%0d", i),
                 {vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].bz, vecs[i].fb, vecs[i].st, vecs[i].ov});
    end

    // Full layer with a scoreboard of addresses and data.
    drive(1, 0, 0, 64'd0);
    check_outs("reset", 27'd0);
    for (int a = 0; a < 64; a++) hits[a] = 0;
    writes = 0; fbcount = 0;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 10; c++) begin
        drive(0, 1, (c == 0), {16'(100+p*4), 16'(101+p*4), 16'(102+p*4), 16'(103+p*4)});
        if (ram_we) begin
          writes++;
          hits[ram_addr]++;
          idx = int'(ram_addr) - 8;
          check_val($sformatf("full_wdata@%0d", ram_addr), int'(ram_wdata),
                    100 + (idx % 4) * 4 + idx / 4);
        end
        if (ram_feedback) begin
          fbcount++;
          check_val("feedback_on_write", writes, 16);
        end
      end
    end
    bad = 0;
    for (int a = 0; a < 64; a++) begin
      if ((a >= 8 && a < 24) ? (hits[a] != 1) : (hits[a] != 0)) bad++;
    end
    check_val("full_writes", writes, 16);
    check_val("full_addr_coverage", bad, 0);
    check_val("full_feedback_count", fbcount, 1);
    check_outs("full_stored", {1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0});

    drive(0, 1, 1, {16'd5, 16'd5, 16'd5, 16'd5});
    check_outs("fifth_sample_overrun", {1'b0, 6'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1});
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 64'd0);
      check_val("fifth_sample_no_write", int'(ram_we), 0);
    end

    // Reset while layer_stored is held.
    drive(1, 1, 0, 64'd0);
    check_outs("reset_stored", 27'd0);

    // Reset mid-pixel, with a sample present during reset.
    drive(0, 1, 1, {16'd41, 16'd42, 16'd43, 16'd44});
    drive(0, 1, 0, 64'd0);
    check_outs("pre_reset_write", {1'b1, 6'd12, 16'd42, 1'b1, 1'b0, 1'b0, 1'b0});
    drive(1, 1, 1, {16'd51, 16'd52, 16'd53, 16'd54});
    check_outs("reset_mid_write", 27'd0);
    for (int c = 0; c < 4; c++) begin
      drive(0, 1, 0, 64'd0);
      check_outs("after_reset_idle", 27'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
